div_share_arbiter: RTL and testbench
====================================

// Module: div_share_arbiter
// PURPOSE
//  Shares one iterative 32-bit divider (start/done handshake) between NUM_REQ requesters.
//  Arbitrates round-robin and latches the winner's operands.
//  Sequences the divider's start/done protocol and returns the result, tagged with the requester id, on one response bus.
//  Sits between client units (e.g. address/stat calculators) and the shared divider instance.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ID_W     2  requester id width; 2**ID_W >= NUM_REQ
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           asynchronous, active-high
//  req_valid      in   NUM_REQ     per-requester request valid
//  req_dividend   in   32*NUM_REQ  dividend, requester i at [32*i +: 32]
//  req_divisor    in   32*NUM_REQ  divisor, requester i at [32*i +: 32]
//  req_ready      out  NUM_REQ     one-hot grant; handshake when req_valid[i] & req_ready[i]
//  rsp_valid      out  1           response valid
//  rsp_ready      in   1           response accepted
//  rsp_id         out  ID_W        index of the requester being answered
//  rsp_quotient   out  32          quotient
//  rsp_remainder  out  32          remainder
//  rsp_err        out  1           divisor was zero
//  div_start      out  1           to divider start (level, held until done seen)
//  div_dividend   out  32          to divider dividend
//  div_divisor    out  32          to divider divisor
//  div_quotient   in   32          from divider
//  div_remainder  in   32          from divider
//  div_done       in   1           from divider; high until start drops, clears one cycle later
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer = NUM_REQ-1 (requester 0 has first priority). Async assert, sync release.
//  Reset mid-operation aborts the transaction with no response. The divider shares the same reset.
//  States:
//   IDLE: req_ready is combinational and asserted only in IDLE.
//    Grant goes to the first valid requester after the RR pointer, wrapping.
//    On grant: latch operands and id, set pointer to the winner.
//    If divisor==0 -> RESP with quotient=remainder=32'hFFFFFFFF, err=1, and div_start never asserted.
//    Otherwise -> BUSY.
//   BUSY: div_start=1; div_dividend/div_divisor hold the latched operands.
//    On div_done=1: capture div_quotient/div_remainder, drop div_start, go to RESP.
//   RESP: rsp_valid=1; rsp_* stable; div_start=0.
//    Leave for IDLE only when rsp_ready=1 and div_done=0 in the same cycle. Otherwise stay.
//  Latency:
//   div_start rises the cycle after the grant handshake.
//   rsp_valid rises the cycle after div_done is first sampled high.
//   Zero divisor: rsp_valid rises the cycle after the grant.
//  One transaction in flight. No new grant before the response is accepted and div_done is low.
//  div_dividend/div_divisor = 0 outside BUSY.
//  Simultaneous requests: exactly one grant per IDLE cycle; losers keep req_valid and are served in RR order.
//  A requester dropping req_valid while ungranted is simply skipped; no grant is ever issued to a non-valid requester.
//  The arbiter does not time out; divider latency = quotient+1 cycles.
// TESTING
//  Req0 20/4 alone -> single req_ready[0] pulse; rsp id=0 q=5 r=0 err=0; div_start high only in BUSY.
//  Req0-3 all valid, operands 17/3 each -> grants in order 0,1,2,3; each rsp q=5 r=2; req1 re-requests after -> served after 3.
//  Req2 25/0 -> rsp id=2 q=r=FFFFFFFF err=1 one cycle after grant; div_start stays 0.
//  Req1 7/8 with rsp_ready low 5 cycles -> rsp q=0 r=7 stable; no req_ready while waiting.
//  Req3 100/10, reset asserted in BUSY -> all outputs 0 immediately.
//   After release, req0 100/10 -> q=10 r=0 id=0.

Source files
------------

// File: rtl/div_share_arbiter_if.sv
// Signal bundle between the shared-divider arbiter, its requesters and the divider.
// The master view belongs to the arbiter; the slave view is the surrounding logic.
interface div_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_dividend;
    logic [32*NUM_REQ-1:0] req_divisor;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_quotient;
    logic [31:0]           rsp_remainder;
    logic                  rsp_err;

    logic                  div_start;
    logic [31:0]           div_dividend;
    logic [31:0]           div_divisor;
    logic [31:0]           div_quotient;
    logic [31:0]           div_remainder;
    logic                  div_done;

    modport master (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_done,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
               div_start, div_dividend, div_divisor
    );

    modport slave (
        output req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_done,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
               div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative divider between NUM_REQ requesters;
// one transaction in flight, result returned tagged with the requester id.
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    div_share_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     ptr_r;
    logic [31:0]         op_dividend_r;
    logic [31:0]         op_divisor_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [31:0]         rsp_quotient_r;
    logic [31:0]         rsp_remainder_r;
    logic                rsp_err_r;

    logic [NUM_REQ-1:0]  higher_s;
    logic [NUM_REQ-1:0]  cand_s;
    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                grant_s;
    logic [31:0]         grant_dividend_s;
    logic [31:0]         grant_divisor_s;

    // Round-robin pick: requesters above the pointer first, otherwise wrap to the lowest valid one.
    always_comb begin
        higher_s         = '0;
        grant_idx_s      = '0;
        grant_dividend_s = 32'd0;
        grant_divisor_s  = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(ptr_r)) begin
                higher_s[i] = bus.req_valid[i];
            end else begin
                higher_s[i] = 1'b0;
            end
        end
        cand_s        = (|higher_s) ? higher_s : bus.req_valid;
        grant_found_s = |cand_s;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                grant_idx_s = ID_W'(i);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == ID_W'(i)) begin
                grant_dividend_s = bus.req_dividend[32*i +: 32];
                grant_divisor_s  = bus.req_divisor[32*i +: 32];
            end else begin
                grant_dividend_s = grant_dividend_s;
                grant_divisor_s  = grant_divisor_s;
            end
        end
    end

    assign grant_s = (state_r == ST_IDLE) && grant_found_s;

    // One-hot ready decode, only ever towards a valid requester.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s && (grant_idx_s == ID_W'(i))) begin
                bus.req_ready[i] = 1'b1;
            end else begin
                bus.req_ready[i] = 1'b0;
            end
        end
    end

    // Next-state logic; RESP waits for both the consumer and the divider's done to clear.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = (grant_divisor_s == 32'd0) ? ST_RESP : ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.div_done) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready && !bus.div_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch on grant, result capture on done; zero divisor answers directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r           <= ID_W'(NUM_REQ - 1);
            op_dividend_r   <= 32'd0;
            op_divisor_r    <= 32'd0;
            rsp_id_r        <= '0;
            rsp_quotient_r  <= 32'd0;
            rsp_remainder_r <= 32'd0;
            rsp_err_r       <= 1'b0;
        end else if (grant_s) begin
            ptr_r         <= grant_idx_s;
            op_dividend_r <= grant_dividend_s;
            op_divisor_r  <= grant_divisor_s;
            rsp_id_r      <= grant_idx_s;
            if (grant_divisor_s == 32'd0) begin
                rsp_quotient_r  <= 32'hFFFF_FFFF;
                rsp_remainder_r <= 32'hFFFF_FFFF;
                rsp_err_r       <= 1'b1;
            end
        end else if ((state_r == ST_BUSY) && bus.div_done) begin
            rsp_quotient_r  <= bus.div_quotient;
            rsp_remainder_r <= bus.div_remainder;
            rsp_err_r       <= 1'b0;
        end
    end

    assign bus.div_start     = (state_r == ST_BUSY);
    assign bus.div_dividend  = (state_r == ST_BUSY) ? op_dividend_r : 32'd0;
    assign bus.div_divisor   = (state_r == ST_BUSY) ? op_divisor_r  : 32'd0;
    assign bus.rsp_valid     = (state_r == ST_RESP);
    assign bus.rsp_id        = rsp_id_r;
    assign bus.rsp_quotient  = rsp_quotient_r;
    assign bus.rsp_remainder = rsp_remainder_r;
    assign bus.rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: divider model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_div_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic reset;

    div_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    div_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Iterative divider: done after quotient+1 edges of start, drops one edge after start does.
    logic [31:0] dv_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_cnt            <= 32'd0;
            bus.div_done      <= 1'b0;
            bus.div_quotient  <= 32'd0;
            bus.div_remainder <= 32'd0;
        end else if (!bus.div_start) begin
            dv_cnt       <= 32'd0;
            bus.div_done <= 1'b0;
        end else if (!bus.div_done) begin
            if (bus.div_divisor == 32'd0) begin
                bus.div_done      <= 1'b1;
                bus.div_quotient  <= 32'hFFFF_FFFF;
                bus.div_remainder <= 32'hFFFF_FFFF;
            end else if (dv_cnt >= bus.div_dividend / bus.div_divisor) begin
                bus.div_done      <= 1'b1;
                bus.div_quotient  <= bus.div_dividend / bus.div_divisor;
                bus.div_remainder <= bus.div_dividend % bus.div_divisor;
            end else begin
                dv_cnt <= dv_cnt + 32'd1;
            end
        end
    end

    int cmp_tests = 0;
    int cmp_fail  = 0;
    int dir_tests = 0;
    int dir_fail  = 0;

    int          cyc = 0;
    int          start_hi_cnt = 0;
    int          grant_cyc = 0;
    int          rsp_rise_cyc = 0;
    int          grant_log[$];
    int          rsp_id_log[$];
    logic [31:0] rsp_q_log[$];
    logic [31:0] rsp_r_log[$];
    logic        rsp_err_log[$];

    task automatic cchk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_tests++;
        if (act !== exp) begin
            cmp_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic dchk(input string name, input logic [63:0] act, input logic [63:0] exp);
        dir_tests++;
        if (act !== exp) begin
            dir_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, round-robin from the last winner.
    initial begin : cmp
        bit                 inflight;
        bit                 have_result;
        bit                 prev_rsp_valid;
        int                 m_ptr;
        int                 m_id;
        int                 pick;
        logic [31:0]        m_dvd;
        logic [31:0]        m_dvs;
        logic [31:0]        exp_q;
        logic [31:0]        exp_r;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 exp_start;
        inflight = 1'b0; have_result = 1'b0; prev_rsp_valid = 1'b0;
        m_ptr = NUM_REQ - 1; m_id = 0; m_dvd = 32'd0; m_dvs = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.div_start) start_hi_cnt++;
            if (reset) begin
                cchk("reset_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.div_start, bus.rsp_id}), 64'd0);
                cchk("reset_data", 64'(bus.rsp_quotient | bus.rsp_remainder | bus.div_dividend | bus.div_divisor), 64'd0);
                inflight = 1'b0; have_result = 1'b0; prev_rsp_valid = 1'b0;
                m_ptr = NUM_REQ - 1;
            end else begin
                pick = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NUM_REQ;
                    if (pick < 0 && bus.req_valid[idx]) pick = idx;
                end
                exp_ready = '0;
                if (!inflight && pick >= 0) exp_ready[pick] = 1'b1;
                exp_start = inflight && !have_result;
                cchk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
                cchk("div_start", 64'(bus.div_start), 64'(exp_start));
                cchk("div_dividend", 64'(bus.div_dividend), exp_start ? 64'(m_dvd) : 64'd0);
                cchk("div_divisor", 64'(bus.div_divisor), exp_start ? 64'(m_dvs) : 64'd0);
                cchk("rsp_valid", 64'(bus.rsp_valid), 64'(have_result));
                if (have_result) begin
                    exp_q = (m_dvs == 32'd0) ? 32'hFFFF_FFFF : m_dvd / m_dvs;
                    exp_r = (m_dvs == 32'd0) ? 32'hFFFF_FFFF : m_dvd % m_dvs;
                    cchk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
                    cchk("rsp_quotient", 64'(bus.rsp_quotient), 64'(exp_q));
                    cchk("rsp_remainder", 64'(bus.rsp_remainder), 64'(exp_r));
                    cchk("rsp_err", 64'(bus.rsp_err), 64'(m_dvs == 32'd0));
                end
                if (bus.rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
                prev_rsp_valid = bus.rsp_valid;
                if (!inflight) begin
                    if (pick >= 0) begin
                        inflight = 1'b1; m_ptr = pick; m_id = pick;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (i == pick) begin
                                m_dvd = bus.req_dividend[32*i +: 32];
                                m_dvs = bus.req_divisor[32*i +: 32];
                            end
                        end
                        have_result = (m_dvs == 32'd0);
                        grant_log.push_back(pick);
                        grant_cyc = cyc;
                    end
                end else if (!have_result) begin
                    if (bus.div_done) have_result = 1'b1;
                end else if (bus.rsp_ready && !bus.div_done) begin
                    rsp_id_log.push_back(int'(bus.rsp_id));
                    rsp_q_log.push_back(bus.rsp_quotient);
                    rsp_r_log.push_back(bus.rsp_remainder);
                    rsp_err_log.push_back(bus.rsp_err);
                    inflight = 1'b0; have_result = 1'b0;
                end
            end
        end
    end

    bit          pending[NUM_REQ];
    bit          rereq[NUM_REQ];
    logic [31:0] s_dvd[NUM_REQ];
    logic [31:0] s_dvs[NUM_REQ];

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]             = pending[i];
            bus.req_dividend[32*i +: 32] = s_dvd[i];
            bus.req_divisor[32*i +: 32]  = s_dvs[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                pending[i] = rereq[i];
                rereq[i]   = 1'b0;
            end
        end
        @(posedge clk);
        #2;
        drive();
    endtask

    task automatic req(input int id, input logic [31:0] dvd, input logic [31:0] dvs);
        s_dvd[id] = dvd; s_dvs[id] = dvs; pending[id] = 1'b1;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin pending[i] = 1'b0; rereq[i] = 1'b0; end
        drive();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (rsp_id_log.size() < target && n < budget) begin step(); n++; end
        dchk(name, 64'(rsp_id_log.size()), 64'(target));
    endtask

    task automatic chk_rsp(input string name, input int k, input int id, input logic [31:0] q,
                           input logic [31:0] r, input logic err);
        if (rsp_id_log.size() > k) begin
            dchk({name, "_id"}, 64'(rsp_id_log[k]), 64'(id));
            dchk({name, "_q"}, 64'(rsp_q_log[k]), 64'(q));
            dchk({name, "_r"}, 64'(rsp_r_log[k]), 64'(r));
            dchk({name, "_err"}, 64'(rsp_err_log[k]), 64'(err));
        end else begin
            dchk({name, "_present"}, 64'(rsp_id_log.size()), 64'(k + 1));
        end
    endtask

    initial begin : stim
        int base_r;
        int base_g;
        int base_s;
        int n;
        int exp_order[5];
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = 1'b0; rereq[i] = 1'b0; s_dvd[i] = 32'd0; s_dvs[i] = 32'd0;
        end
        bus.rsp_ready = 1'b0;
        do_reset();

        // Lone request 20/4
        bus.rsp_ready = 1'b1;
        base_r = rsp_id_log.size(); base_g = grant_log.size(); base_s = start_hi_cnt;
        req(0, 32'd20, 32'd4);
        wait_rsp(base_r + 1, 100, "t1_rsp_count");
        chk_rsp("t1", base_r, 0, 32'd5, 32'd0, 1'b0);
        dchk("t1_grants", 64'(grant_log.size() - base_g), 64'd1);
        dchk("t1_start_cycles", 64'(start_hi_cnt - base_s), 64'd7);

        // All four 17/3, requester 1 asks again right after its grant
        do_reset();
        base_r = rsp_id_log.size(); base_g = grant_log.size();
        for (int i = 0; i < NUM_REQ; i++) begin s_dvd[i] = 32'd17; s_dvs[i] = 32'd3; pending[i] = 1'b1; end
        rereq[1] = 1'b1;
        drive();
        wait_rsp(base_r + 5, 200, "t2_rsp_count");
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > base_g + k) dchk("t2_grant_order", 64'(grant_log[base_g + k]), 64'(exp_order[k]));
            else dchk("t2_grant_present", 64'(grant_log.size()), 64'(base_g + k + 1));
            chk_rsp("t2", base_r + k, exp_order[k], 32'd5, 32'd2, 1'b0);
        end

        // Zero divisor
        do_reset();
        base_r = rsp_id_log.size(); base_s = start_hi_cnt;
        req(2, 32'd25, 32'd0);
        wait_rsp(base_r + 1, 50, "t3_rsp_count");
        chk_rsp("t3", base_r, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        dchk("t3_latency", 64'(rsp_rise_cyc - grant_cyc), 64'd1);
        dchk("t3_no_start", 64'(start_hi_cnt - base_s), 64'd0);

        // Response held off for 5 cycles
        do_reset();
        bus.rsp_ready = 1'b0;
        base_r = rsp_id_log.size();
        req(1, 32'd7, 32'd8);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin step(); n++; end
        dchk("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        req(0, 32'd9, 32'd3);
        base_g = grant_log.size();
        repeat (5) step();
        dchk("t4_no_grant", 64'(grant_log.size() - base_g), 64'd0);
        dchk("t4_still_valid", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        wait_rsp(base_r + 2, 100, "t4_rsp_count");
        chk_rsp("t4a", base_r, 1, 32'd0, 32'd7, 1'b0);
        chk_rsp("t4b", base_r + 1, 0, 32'd3, 32'd0, 1'b0);

        // Reset while the divider is running
        do_reset();
        base_r = rsp_id_log.size();
        req(3, 32'd100, 32'd10);
        n = 0;
        while (!bus.div_start && n < 20) begin step(); n++; end
        dchk("t5_busy", 64'(bus.div_start), 64'd1);
        repeat (3) step();
        reset = 1'b1;
        #1;
        dchk("t5_reset_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.div_start, bus.rsp_id}), 64'd0);
        dchk("t5_reset_data", 64'(bus.rsp_quotient | bus.rsp_remainder | bus.div_dividend | bus.div_divisor), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) step();
        dchk("t5_aborted", 64'(rsp_id_log.size()), 64'(base_r));
        req(0, 32'd100, 32'd10);
        wait_rsp(base_r + 1, 200, "t5_rsp_count");
        chk_rsp("t5", base_r, 0, 32'd10, 32'd0, 1'b0);

        // Randomized traffic with back-pressure and requesters that give up
        do_reset();
        base_r = rsp_id_log.size();
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && $urandom_range(0, 99) < 15) begin
                    s_dvd[i]   = 32'($urandom_range(0, 200));
                    s_dvs[i]   = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 16));
                    pending[i] = 1'b1;
                end else if (pending[i] && $urandom_range(0, 99) < 2) begin
                    pending[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            drive();
        end
        dchk("rand_progress", 64'((rsp_id_log.size() - base_r) > 10), 64'd1);

        $display("[TB] %0d tests run, %0d failed", cmp_tests + dir_tests, cmp_fail + dir_fail);
        $finish;
    end
endmodule
